djs130_tto_fifo: RTL and testbench

- Second-generation DJS130 teletype-output (TTO) device: a buffered, parametrised console that renders ASCII output into the GDU text VRAM.
- CPU writes are decoupled from screen rendering by a character FIFO, so DONE returns as soon as a character is queued.
- Adds carriage return, tab expansion, wrap-without-loss and a configurable line width and write-pulse length.
- Sits on the DJS130 device bus (device code DEV_DMs) and drives the VRAM write port and the GDU Y-scroll offset.

---
 rtl/djs130_tto_pkg.sv | 31 +++
 rtl/djs130_char_fifo.sv | 53 +++++
 rtl/djs130_tto_fifo.sv | 263 ++++++++++++++++++++++++++
 tb/tb_djs130_tto_fifo.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/djs130_tto_pkg.sv
// Shared definitions for the DJS130 buffered TTO console: renderer states,
// control-character codes and device-bus strobe bit positions.
package djs130_tto_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_ADVANCE,
        S_NL_SCROLL,
        S_NL_CLEAR,
        S_NL_DONE
    } state_t;

    localparam logic [7:0] NUL = 8'd0;
    localparam logic [7:0] BEL = 8'd7;
    localparam logic [7:0] BS  = 8'd8;
    localparam logic [7:0] HT  = 8'd9;
    localparam logic [7:0] LF  = 8'd10;
    localparam logic [7:0] CR  = 8'd13;
    localparam logic [7:0] DC3 = 8'd19;
    localparam logic [7:0] ETB = 8'd23;
    localparam logic [7:0] EM  = 8'd25;
    localparam logic [7:0] SUB = 8'd26;

    localparam int unsigned KZ_DOA = 0;
    localparam int unsigned KZ_S   = 6;
    localparam int unsigned KZ_C   = 7;

endpackage

// File: rtl/djs130_char_fifo.sv
// Synchronous show-ahead FIFO with async active-high reset; DEPTH must be a
// power of two so the pointers wrap naturally.
module djs130_char_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/djs130_tto_fifo.sv
// DJS130 buffered TTO console: bus front end queues characters, renderer FSM
// draws them into GDU VRAM. Define TTO_TAB_EN to enable HT tab expansion.
module djs130_tto_fifo
    import djs130_tto_pkg::*;
#(
    parameter logic [5:0]  DEV_DMs      = 6'o11,
    parameter logic [7:0]  TTO_COLOR    = 8'hff,
    parameter logic [6:0]  TTO_LINE_MAX = 7'd80,
    parameter logic [7:0]  TTO_SPACE    = 8'd32,
    parameter logic [4:0]  TTO_Y        = 5'd29,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned TAB_WIDTH    = 8,
    parameter int unsigned WR_CYCLES    = 3
) (
    input  logic        i_vram_clk,
    input  logic        i_dev_ZZ0,
    input  logic [8:0]  i_dev_KZ,
    input  logic [15:0] i_dev_SR,
    output logic        o_dev_ZDQQ,
    output logic [1:0]  o_dev_ZT,
    output logic [5:0]  o_dev_DMs,
    output logic        o_vram_we,
    output logic        o_vram_ce,
    output logic [15:0] o_vram_data,
    output logic [11:0] o_vram_addr,
    output logic [4:0]  o_vram_yoffset
);
    localparam int unsigned CNT_W = $clog2(WR_CYCLES + 1);
    localparam logic [6:0]  TAB_MASK = 7'(TAB_WIDTH - 1);

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic       busy;
    logic       done;
    logic       pending;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] fifo_dout;
    logic       unused;

    assign clk    = i_vram_clk;
    assign rst    = i_dev_ZZ0;
    assign unused = ^{i_dev_KZ[8], i_dev_KZ[5:1], i_dev_SR[15:8]};

    // A pending push yields to a same-edge S or C so C can cancel a stalled character.
    assign push = pending && !full && !i_dev_KZ[KZ_C] && !i_dev_KZ[KZ_S];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (i_dev_KZ[KZ_DOA]) a <= i_dev_SR[7:0];
            if (i_dev_KZ[KZ_C]) begin
                busy    <= 1'b0;
                done    <= 1'b0;
                pending <= 1'b0;
            end else if (i_dev_KZ[KZ_S]) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                pending <= 1'b1;
            end else if (push) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                pending <= 1'b0;
            end
        end
    end

    djs130_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (a),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    state_t           state, state_n;
    state_t           ret, ret_n;
    logic [7:0]       ch, ch_n;
    logic [6:0]       col, col_n;
    logic [6:0]       col_inc;
    logic [4:0]       yoff, yoff_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             we, we_n;
    logic [7:0]       data, data_n;
    logic [6:0]       wcol, wcol_n;
    logic             clearing, clearing_n;
    logic             tab, tab_n;

    assign col_inc = col + 7'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ret      <= S_IDLE;
            ch       <= '0;
            col      <= '0;
            yoff     <= '0;
            cnt      <= '0;
            we       <= 1'b0;
            data     <= '0;
            wcol     <= '0;
            clearing <= 1'b0;
            tab      <= 1'b0;
        end else begin
            state    <= state_n;
            ret      <= ret_n;
            ch       <= ch_n;
            col      <= col_n;
            yoff     <= yoff_n;
            cnt      <= cnt_n;
            we       <= we_n;
            data     <= data_n;
            wcol     <= wcol_n;
            clearing <= clearing_n;
            tab      <= tab_n;
        end
    end

    // Address/data are loaded on entry to S_WRITE; we rises one clock later.
    always_comb begin
        state_n    = state;
        ret_n      = ret;
        ch_n       = ch;
        col_n      = col;
        yoff_n     = yoff;
        cnt_n      = cnt;
        we_n       = 1'b0;
        data_n     = data;
        wcol_n     = wcol;
        clearing_n = clearing;
        tab_n      = tab;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) state_n = S_FETCH;
            end
            S_FETCH: begin
                pop     = 1'b1;
                ch_n    = fifo_dout;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                case (ch)
                    NUL, BEL, DC3, ETB, SUB: state_n = S_IDLE;
                    BS, EM: begin
                        if (col != '0) col_n = col - 7'd1;
                        state_n = S_IDLE;
                    end
                    CR: begin
                        col_n   = '0;
                        state_n = S_IDLE;
                    end
                    LF: begin
                        ret_n   = S_IDLE;
                        state_n = S_NL_SCROLL;
                    end
`ifdef TTO_TAB_EN
                    HT: begin
                        if (col == TTO_LINE_MAX) begin
                            ret_n   = S_IDLE;
                            state_n = S_NL_SCROLL;
                        end else begin
                            tab_n   = 1'b1;
                            data_n  = TTO_SPACE;
                            wcol_n  = col;
                            cnt_n   = '0;
                            state_n = S_WRITE;
                        end
                    end
`else
                    HT: state_n = S_IDLE;
`endif
                    default: begin
                        if (col == TTO_LINE_MAX) begin
                            ret_n   = S_WRITE;
                            state_n = S_NL_SCROLL;
                        end else begin
                            data_n  = ch;
                            wcol_n  = col;
                            cnt_n   = '0;
                            state_n = S_WRITE;
                        end
                    end
                endcase
            end
            S_WRITE: begin
                if (cnt != CNT_W'(WR_CYCLES)) begin
                    we_n  = 1'b1;
                    cnt_n = cnt + CNT_W'(1);
                end else if (clearing) begin
                    if (col == TTO_LINE_MAX - 7'd1) begin
                        state_n = S_NL_DONE;
                    end else begin
                        col_n   = col_inc;
                        state_n = S_NL_CLEAR;
                    end
                end else begin
                    state_n = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                col_n = col_inc;
                if (tab && col_inc != TTO_LINE_MAX && (col_inc & TAB_MASK) != '0) begin
                    data_n  = TTO_SPACE;
                    wcol_n  = col_inc;
                    cnt_n   = '0;
                    state_n = S_WRITE;
                end else begin
                    tab_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            S_NL_SCROLL: begin
                yoff_n     = yoff + 5'd1;
                col_n      = '0;
                clearing_n = 1'b1;
                state_n    = S_NL_CLEAR;
            end
            S_NL_CLEAR: begin
                data_n  = TTO_SPACE;
                wcol_n  = col;
                cnt_n   = '0;
                state_n = S_WRITE;
            end
            S_NL_DONE: begin
                col_n      = '0;
                clearing_n = 1'b0;
                if (ret == S_WRITE) begin
                    data_n  = ch;
                    wcol_n  = '0;
                    cnt_n   = '0;
                    state_n = S_WRITE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign o_dev_ZDQQ     = done;
    assign o_dev_ZT       = {done, busy};
    assign o_dev_DMs      = DEV_DMs;
    assign o_vram_we      = we;
    assign o_vram_ce      = we;
    assign o_vram_data    = {TTO_COLOR, data};
    assign o_vram_addr    = {wcol, TTO_Y};
    assign o_vram_yoffset = yoff;

endmodule

// File: tb/tb_djs130_tto_fifo.sv
// Scoreboard bench for djs130_tto_fifo: a character-level console model
// predicts VRAM writes; a monitor checks every write pulse against it.
module tb_djs130_tto_fifo;

    localparam logic [7:0] COLOR    = 8'hff;
    localparam int         LINE_MAX = 80;
    localparam logic [7:0] SP       = 8'd32;
    localparam logic [4:0] TY       = 5'd29;
    localparam int         TABW     = 8;
    localparam int         WRC      = 3;
    localparam logic [8:0] K_DOA    = 9'h001;
    localparam logic [8:0] K_S      = 9'h040;
    localparam logic [8:0] K_C      = 9'h080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  kz  = '0;
    logic [15:0] sr  = '0;
    logic        zdqq;
    logic [1:0]  zt;
    logic [5:0]  dms;
    logic        we;
    logic        ce;
    logic [15:0] vdata;
    logic [11:0] vaddr;
    logic [4:0]  yoffset;

    always #5 clk = ~clk;

    djs130_tto_fifo #(
        .DEV_DMs      (6'o11),
        .TTO_COLOR    (COLOR),
        .TTO_LINE_MAX (7'(LINE_MAX)),
        .TTO_SPACE    (SP),
        .TTO_Y        (TY),
        .FIFO_DEPTH   (16),
        .TAB_WIDTH    (TABW),
        .WR_CYCLES    (WRC)
    ) dut (
        .i_vram_clk     (clk),
        .i_dev_ZZ0      (rst),
        .i_dev_KZ       (kz),
        .i_dev_SR       (sr),
        .o_dev_ZDQQ     (zdqq),
        .o_dev_ZT       (zt),
        .o_dev_DMs      (dms),
        .o_vram_we      (we),
        .o_vram_ce      (ce),
        .o_vram_data    (vdata),
        .o_vram_addr    (vaddr),
        .o_vram_yoffset (yoffset)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [27:0] exp_q[$];
    int model_col = 0;
    int model_y   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input int info);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (info %0d)", name, info);
    endtask

    task automatic model_write(input int c, input logic [7:0] chr);
        exp_q.push_back({7'(c), TY, COLOR, chr});
    endtask

    task automatic model_newline();
        model_y = (model_y + 1) % 32;
        for (int i = 0; i < LINE_MAX; i++) model_write(i, SP);
        model_col = 0;
    endtask

    task automatic model_char(input logic [7:0] c);
        case (c)
            8'd0, 8'd7, 8'd19, 8'd23, 8'd26: ;
            8'd8, 8'd25: if (model_col > 0) model_col--;
            8'd13: model_col = 0;
            8'd10: model_newline();
            8'd9: begin
`ifdef TTO_TAB_EN
                if (model_col == LINE_MAX) begin
                    model_newline();
                end else begin
                    model_write(model_col, SP);
                    model_col++;
                    while (model_col % TABW != 0 && model_col < LINE_MAX) begin
                        model_write(model_col, SP);
                        model_col++;
                    end
                end
`endif
            end
            default: begin
                if (model_col == LINE_MAX) model_newline();
                model_write(model_col, c);
                model_col++;
            end
        endcase
    endtask

    // Write-pulse monitor: checks each pulse against the scoreboard head.
    logic        prev_we = 1'b0;
    logic [11:0] prev_addr;
    logic [15:0] prev_data;
    logic [11:0] p_addr;
    logic [15:0] p_data;
    int          p_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
            p_len   = 0;
        end else begin
            if (we && !prev_we) begin
                check("ce_follows_we", {31'd0, ce}, 32'd1);
                check("addr_setup", {20'd0, prev_addr}, {20'd0, vaddr});
                check("data_setup", {16'd0, prev_data}, {16'd0, vdata});
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h, required no write", vaddr, vdata);
                end else begin
                    check("write", {4'd0, vaddr, vdata}, {4'd0, exp_q.pop_front()});
                end
                p_addr = vaddr;
                p_data = vdata;
                p_len  = 1;
            end else if (we && prev_we) begin
                p_len++;
                check("write_stable", {4'd0, vaddr, vdata}, {4'd0, p_addr, p_data});
            end else if (!we && prev_we) begin
                check("pulse_len", p_len, WRC);
            end
            prev_we = we;
        end
        prev_addr = vaddr;
        prev_data = vdata;
    end

    task automatic strobe(input logic [8:0] k, input logic [15:0] d);
        @(negedge clk);
        kz = k;
        sr = d;
        @(negedge clk);
        kz = '0;
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        if ($urandom_range(0, 1) == 1) begin
            strobe(K_DOA | K_S, {8'($urandom), c});
        end else begin
            strobe(K_DOA, {8'($urandom), c});
            strobe(K_S, 16'($urandom));
        end
        while (!zdqq && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!zdqq) fail("send_done", c);
        else model_char(c);
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 20 && n < 6000) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !we) quiet++;
            else quiet = 0;
        end
        if (quiet < 20) fail({name, "_idle"}, exp_q.size());
        check({name, "_col"}, 32'(dut.col), 32'(model_col));
        check({name, "_yoffset"}, 32'(yoffset), 32'(model_y));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"}, {31'd0, we}, 32'd0);
        check({name, "_ce"}, {31'd0, ce}, 32'd0);
        check({name, "_zt"}, 32'(zt), 32'd0);
        check({name, "_zdqq"}, {31'd0, zdqq}, 32'd0);
        check({name, "_data"}, 32'(vdata), {16'd0, COLOR, 8'h00});
        check({name, "_addr"}, 32'(vaddr), {20'd0, 7'd0, TY});
        check({name, "_yoffset"}, 32'(yoffset), 32'd0);
    endtask

    initial begin
        int n;
        int lf_left;
        logic [7:0] c;
        logic [7:0] ign [5];
        ign = '{8'd0, 8'd7, 8'd19, 8'd23, 8'd26};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("dms", 32'(dms), 32'o11);
        rst = 1'b0;

        // First character with explicit status timing.
        strobe(K_DOA, 16'h0041);
        strobe(K_S, 16'h0000);
        check("zt_after_s", 32'(zt), 32'd1);
        @(negedge clk);
        check("zt_done", 32'(zt), 32'd2);
        check("zdqq_done", {31'd0, zdqq}, 32'd1);
        model_char(8'h41);
        wait_idle("first_char");

        // Full line then one more: wrap scrolls and clears before printing.
        send(8'd13);
        for (int i = 0; i < 80; i++) send(8'h41);
        send(8'h42);
        wait_idle("wrap");

        // CR returns to column 0; BS at column 0 stays put.
        send(8'h41);
        send(8'h42);
        send(8'd13);
        send(8'h43);
        send(8'd13);
        send(8'd8);
        wait_idle("cr_bs");

        // S and C on the same edge: C wins.
        strobe(K_S | K_C, 16'h0000);
        check("s_c_same_edge", 32'(zt), 32'd0);
        wait_idle("s_c");

        // Fill the FIFO behind a newline clear, then stall the 17th.
        send(8'd10);
        for (int i = 0; i < 16; i++) send(8'h61 + 8'(i));
        strobe(K_DOA | K_S, 16'h0071);
        for (int i = 0; i < 5; i++) begin
            check("stall_busy", 32'(zt), 32'd1);
            @(negedge clk);
        end
        n = 0;
        while (!zdqq && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!zdqq) fail("stall_release", n);
        else begin
            check("stall_done_zt", 32'(zt), 32'd2);
            model_char(8'h71);
        end
        strobe(K_S, 16'h0000);
        check("stall2_busy", 32'(zt), 32'd1);
        strobe(K_C, 16'h0000);
        check("clear_zt", 32'(zt), 32'd0);
        wait_idle("stall");

        // Tab from column 3.
        send(8'd13);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(8'd9);
        wait_idle("tab");

        // Randomised character stream.
        lf_left = 3;
        for (int i = 0; i < 120; i++) begin
            n = $urandom_range(0, 99);
            if (n < 60) c = 8'($urandom_range(33, 126));
            else if (n < 70) c = SP;
            else if (n < 76) c = 8'd13;
            else if (n < 82) c = ($urandom_range(0, 1) == 1) ? 8'd8 : 8'd25;
            else if (n < 88) c = ign[$urandom_range(0, 4)];
            else if (n < 94) c = 8'd9;
            else if (lf_left > 0) begin
                c = 8'd10;
                lf_left--;
            end else c = 8'h5a;
            send(c);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        wait_idle("random");

        // Reset in the middle of a write pulse.
        send(8'h51);
        n = 0;
        while (!we && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!we) fail("reset_wait_we", n);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midwrite_reset");
        check("midwrite_reset_col", 32'(dut.col), 32'd0);
        exp_q.delete();
        model_col = 0;
        model_y   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(8'h52);
        wait_idle("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
